adc_serial_rx: RTL and testbench

// - Parametrised receiver for simultaneous-sampling serial SAR ADCs (AD7357 class); N data lines share one CS_n/SCLK.
// - Runs one conversion frame per i_sync: asserts CS_n, discards LEAD_BITS, shifts DATA_W bits/channel, discards TRAIL_BITS.
// - Enforces a minimum CS_n-high quiet time; presents results on a valid/ready output with overrun detection.
// - Sits between the ADC pins and the sample FIFO/DSP chain. i_clk is the rebuffered SCLK; all logic runs on negedge i_clk.

---
 rtl/adc_serial_rx.sv | 149 ++++++++++++++
 tb/tb_adc_serial_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// Frames an AD7357-class serial ADC over NUM_CH shared-SCLK lines; commits on the frame-end falling edge (zero extra latency).
// Backpressure: valid/ready output; a frame completing while the previous one is unconsumed is dropped and flags sticky overrun.
module adc_serial_rx #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 14,
   parameter int LEAD_BITS  = 2,
   parameter int TRAIL_BITS = 0,
   parameter int QUIET_CYC  = 1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_sync,
   input  logic [NUM_CH-1:0]        i_if_sdata,
   output logic                     o_if_cs_n,
   output logic                     o_busy,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [NUM_CH*DATA_W-1:0] o_data,
   output logic                     o_overrun,
   input  logic                     i_clr_overrun
);
   localparam int MAXC = (LEAD_BITS > DATA_W) ?
                         ((LEAD_BITS > TRAIL_BITS) ? ((LEAD_BITS > QUIET_CYC) ? LEAD_BITS : QUIET_CYC)
                                                   : ((TRAIL_BITS > QUIET_CYC) ? TRAIL_BITS : QUIET_CYC)) :
                         ((DATA_W > TRAIL_BITS) ? ((DATA_W > QUIET_CYC) ? DATA_W : QUIET_CYC)
                                                : ((TRAIL_BITS > QUIET_CYC) ? TRAIL_BITS : QUIET_CYC));
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] LEAD_LAST  = CW'((LEAD_BITS  > 0) ? LEAD_BITS  - 1 : 0);
   localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_W - 1);
   localparam logic [CW-1:0] TRAIL_LAST = CW'((TRAIL_BITS > 0) ? TRAIL_BITS - 1 : 0);
   localparam logic [CW-1:0] QUIET_LAST = CW'((QUIET_CYC  > 0) ? QUIET_CYC  - 1 : 0);
   localparam int FW = NUM_CH * DATA_W;

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_DATA, S_TRAIL, S_QUIET} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   sr_q, sr_d, sr_shift, commit_dat;
   logic            cs_n_q, cs_n_d;
   logic            valid_q, valid_d;
   logic [FW-1:0]   data_q, data_d;
   logic            ovr_q, ovr_d;
   logic            frame_end;
   logic            ovr_set;

   always_comb begin
      logic [DATA_W-1:0] ch;
      logic [DATA_W-1:0] bitv;
      sr_shift = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch   = sr_q[c*DATA_W +: DATA_W];
         bitv = '0;
         if (MSB_FIRST) begin
            bitv[0] = i_if_sdata[c];
            ch      = (ch << 1) | bitv;
         end else begin
            bitv[DATA_W-1] = i_if_sdata[c];
            ch             = (ch >> 1) | bitv;
         end
         sr_shift[c*DATA_W +: DATA_W] = ch;
      end
   end

   // Without trailing bits the frame ends on the last data edge, so that edge's bit must be included.
   assign commit_dat = (state_q == S_DATA) ? sr_shift : sr_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      cs_n_d    = cs_n_q;
      frame_end = 1'b0;
      case (state_q)
         S_IDLE: if (i_sync) begin
            cs_n_d  = 1'b0;
            cnt_d   = '0;
            sr_d    = '0;
            state_d = (LEAD_BITS > 0) ? S_LEAD : S_DATA;
         end
         S_LEAD: if (cnt_q == LEAD_LAST) begin
            cnt_d   = '0;
            state_d = S_DATA;
         end else cnt_d = cnt_q + 1'b1;
         S_DATA: begin
            sr_d = sr_shift;
            if (cnt_q == DATA_LAST) begin
               cnt_d = '0;
               if (TRAIL_BITS > 0) state_d = S_TRAIL;
               else                frame_end = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_TRAIL: if (cnt_q == TRAIL_LAST) begin
            cnt_d     = '0;
            frame_end = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         S_QUIET: if (cnt_q == QUIET_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end else cnt_d = cnt_q + 1'b1;
         default: state_d = S_IDLE;
      endcase
      if (frame_end) begin
         cs_n_d  = 1'b1;
         state_d = (QUIET_CYC > 0) ? S_QUIET : S_IDLE;
      end

      valid_d = valid_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      ovr_set = 1'b0;
      if (frame_end) begin
         if (!valid_q || i_ready) begin
            data_d  = commit_dat;
            valid_d = 1'b1;
         end else ovr_set = 1'b1;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
      if (ovr_set)            ovr_d = 1'b1;
      else if (i_clr_overrun) ovr_d = 1'b0;
   end

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         cs_n_q  <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         cs_n_q  <= cs_n_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_if_cs_n = cs_n_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_valid   = valid_q;
   assign o_data    = data_q;
   assign o_overrun = ovr_q;
endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: default-config DUT against a frame/handshake reference model, plus a 4-channel LSB-first DUT.
module tb_adc_serial_rx;
   localparam int NC = 2, DW = 14, LB = 2, TR = 0, QC = 1;
   localparam int FW = NC * DW;

   logic clk = 1'b1;
   logic rst_n;
   logic sync, ready, clr;
   logic [NC-1:0] sdata;
   logic cs_n, busy, valid, ovr;
   logic [FW-1:0] data;

   logic sync2, ready2, clr2;
   logic [3:0] sdata2;
   logic cs_n2, busy2, valid2, ovr2;
   logic [47:0] data2;

   always #5 clk = ~clk;

   adc_serial_rx dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sync(sync), .i_if_sdata(sdata),
      .o_if_cs_n(cs_n), .o_busy(busy), .o_valid(valid), .i_ready(ready),
      .o_data(data), .o_overrun(ovr), .i_clr_overrun(clr));

   adc_serial_rx #(.NUM_CH(4), .DATA_W(12), .LEAD_BITS(0), .TRAIL_BITS(3),
                   .QUIET_CYC(1), .MSB_FIRST(1'b0)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sync(sync2), .i_if_sdata(sdata2),
      .o_if_cs_n(cs_n2), .o_busy(busy2), .o_valid(valid2), .i_ready(ready2),
      .o_data(data2), .o_overrun(ovr2), .i_clr_overrun(clr2));

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ADC model: after CS_n falls, one bit per SCLK period, updated on the rising edge.
   logic [FW-1:0] fixed_q[$];
   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] cur;
   int pos = 0;
   always @(posedge clk) begin
      if (cs_n !== 1'b0) begin
         pos   = 0;
         sdata = NC'($urandom);
      end else begin
         if (pos == 0) begin
            if (fixed_q.size() > 0) cur = fixed_q.pop_front();
            else                    cur = FW'({$urandom, $urandom});
            exp_q.push_back(cur);
         end
         for (int c = 0; c < NC; c++) begin
            if (pos >= LB && pos < LB + DW) sdata[c] = cur[c*DW + (DW-1-(pos-LB))];
            else                            sdata[c] = 1'($urandom);
         end
         pos++;
      end
   end

   logic [47:0] cur2;
   int pos2 = 0;
   always @(posedge clk) begin
      if (cs_n2 !== 1'b0) begin
         pos2   = 0;
         sdata2 = 4'($urandom);
      end else begin
         for (int c = 0; c < 4; c++)
            sdata2[c] = (pos2 < 12) ? cur2[c*12 + pos2] : 1'($urandom);
         pos2++;
      end
   end

   // Reference model of the output register and frame timing, evaluated just after each falling edge.
   logic mv = 1'b0, mo = 1'b0, prev_cs = 1'b1, set_o;
   logic [FW-1:0] md = '0, fr;
   int low_cnt = 0, edge_cnt = 0, last_fall = -1;
   bit hold_chk = 1'b0;
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         mv = 1'b0; md = '0; mo = 1'b0; prev_cs = 1'b1;
         low_cnt = 0; last_fall = -1;
         exp_q.delete();
      end else begin
         edge_cnt++;
         set_o = 1'b0;
         if (prev_cs && !cs_n) begin
            if (hold_chk && last_fall >= 0)
               check("frame_period", 64'(edge_cnt - last_fall), 64'(LB + DW + TR + QC + 1));
            last_fall = hold_chk ? edge_cnt : -1;
         end
         if (!prev_cs && cs_n) begin
            // CS_n stays low over edges E0..E(end-1), i.e. end-edge index periods.
            check("cs_low_len", 64'(low_cnt), 64'(LB + DW + TR));
            low_cnt = 0;
            check("frames_in_flight", 64'(exp_q.size()), 64'd1);
            fr = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (!mv || ready) begin md = fr; mv = 1'b1; end
            else set_o = 1'b1;
         end else if (mv && ready) begin
            mv = 1'b0;
         end
         if (!cs_n) low_cnt++;
         if (set_o)    mo = 1'b1;
         else if (clr) mo = 1'b0;
         prev_cs = cs_n;
         check("o_valid", 64'(valid), 64'(mv));
         check("o_data", 64'(data), 64'(md));
         check("o_overrun", 64'(ovr), 64'(mo));
      end
   end

   task automatic pulse_sync();
      @(posedge clk); sync = 1'b1;
      @(posedge clk); sync = 1'b0;
   endtask

   logic [FW-1:0] f1, f2;
   int lowc;

   initial begin
      rst_n = 1'b0; sync = 1'b0; ready = 1'b1; clr = 1'b0;
      sync2 = 1'b0; ready2 = 1'b0; clr2 = 1'b0;
      cur2 = {12'h555, 12'hABC, 12'h800, 12'h001};
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", 64'(cs_n), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_data", 64'(data), 64'd0);
      check("rst_overrun", 64'(ovr), 64'd0);
      check("rst_cs_n2", 64'(cs_n2), 64'd1);
      @(posedge clk); rst_n = 1'b1;

      // Directed single frame: A=0x2A5C, B=0x15A3.
      fixed_q.push_back({14'h15A3, 14'h2A5C});
      pulse_sync();
      repeat (20) @(posedge clk);
      #1;
      check("single_data", 64'(data), 64'({14'h15A3, 14'h2A5C}));
      check("single_idle", 64'(busy), 64'd0);
      check("single_cs_n", 64'(cs_n), 64'd1);

      // Back-to-back frames with sync held.
      @(posedge clk); sync = 1'b1; hold_chk = 1'b1;
      repeat (18 * 5) @(posedge clk);
      #1 check("held_no_overrun", 64'(ovr), 64'd0);
      for (int i = 0; i < 18 * 15; i++) begin
         @(posedge clk);
         ready = 1'($urandom);
         clr   = ($urandom_range(0, 9) == 0);
      end
      @(posedge clk); sync = 1'b0; hold_chk = 1'b0; ready = 1'b1; clr = 1'b1;
      repeat (25) @(posedge clk);
      clr = 1'b0;

      // Consumer stalled across two frames.
      f1 = FW'($urandom); f2 = FW'($urandom);
      ready = 1'b0;
      fixed_q.push_back(f1); fixed_q.push_back(f2);
      pulse_sync();
      repeat (20) @(posedge clk);
      #1;
      check("stall_first_data", 64'(data), 64'(f1));
      check("stall_first_valid", 64'(valid), 64'd1);
      check("stall_first_ovr", 64'(ovr), 64'd0);
      pulse_sync();
      repeat (20) @(posedge clk);
      #1;
      check("stall_held_data", 64'(data), 64'(f1));
      check("stall_overrun", 64'(ovr), 64'd1);
      @(posedge clk); clr = 1'b1;
      @(posedge clk); clr = 1'b0;
      #1 check("clr_overrun", 64'(ovr), 64'd0);
      @(posedge clk); ready = 1'b1;
      @(posedge clk); ready = 1'b0;
      #1 check("ready_consumes", 64'(valid), 64'd0);

      // Commit edge coincides with a consume of the previous frame.
      f1 = FW'($urandom); f2 = FW'($urandom);
      fixed_q.push_back(f1); fixed_q.push_back(f2);
      pulse_sync();
      repeat (20) @(posedge clk);
      pulse_sync();
      repeat (15) @(posedge clk);
      ready = 1'b1;
      @(posedge clk); ready = 1'b0;
      #1;
      check("swap_data", 64'(data), 64'(f2));
      check("swap_valid", 64'(valid), 64'd1);
      check("swap_no_ovr", 64'(ovr), 64'd0);
      @(posedge clk); ready = 1'b1;
      repeat (4) @(posedge clk);

      // Reset in the middle of a frame (at E8).
      pulse_sync();
      repeat (7) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs_n", 64'(cs_n), 64'd1);
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_data", 64'(data), 64'd0);
      repeat (2) @(posedge clk); rst_n = 1'b1;
      f1 = FW'($urandom);
      fixed_q.push_back(f1);
      pulse_sync();
      repeat (20) @(posedge clk);
      #1;
      check("postrst_data", 64'(data), 64'(f1));
      check("postrst_cs_n", 64'(cs_n), 64'd1);

      // Four-channel LSB-first instance with trailing bits.
      lowc = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         if (cs_n2 === 1'b0) lowc++;
         sync2 = (i == 0);
      end
      #1;
      check("ch4_data", 64'(data2), 64'({12'h555, 12'hABC, 12'h800, 12'h001}));
      check("ch4_valid", 64'(valid2), 64'd1);
      check("ch4_cs_low_len", 64'(lowc), 64'd15);
      check("ch4_busy", 64'(busy2), 64'd0);
      cur2 = {$urandom, $urandom_range(0, 65535)};
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         sync2 = (i == 0);
      end
      #1;
      check("ch4_held_data", 64'(data2), 64'({12'h555, 12'hABC, 12'h800, 12'h001}));
      check("ch4_overrun", 64'(ovr2), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
